control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle controller that sits directly upstream of the datapath (op_aut).
- Consumes the datapath's opcode, funct and zero.
- Drives the datapath's PC load, register-file write, mux selects and ALU function, so each instruction takes a fixed FETCH/EXEC/COMMIT sequence.
- Adds run/halt control, illegal-opcode trapping and a retired-instruction counter for test benches.

Parameters:
CountWidth, 16, width of the retired-instruction counter instr_count

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
opcode  input  6  instruction[31:26] from datapath
funct  input  6  instruction[5:0] from datapath
zero  input  1  ALU zero flag from datapath
load  output  1  PC register load enable
write  output  1  register-file write enable
rd_mux_s  output  1  0 = write rt, 1 = write rd
op2_mux_s  output  1  0 = rdata2, 1 = sign-extended immediate
branch_mux_s  output  1  0 = PC+4, 1 = PC+4+imm
alu_funct  output  6  ALU operation code (MIPS funct encoding)
busy  output  1  1 while in FETCH, EXEC or COMMIT
halted  output  1  sticky; HALT instruction retired
illegal  output  1  sticky; unsupported instruction decoded
instr_count  output  CountWidth  number of retired instructions, saturating

Behaviour:
- Reset (reset==0 at clock edge): state=IDLE; all outputs 0; instr_count=0; decode registers cleared. Reset mid-instruction aborts it; no partial load/write is issued in the reset cycle.
- States: IDLE, FETCH, EXEC, COMMIT, HALT, ERR.
- IDLE: go to FETCH when run==1.
- FETCH: opcode/funct are valid combinationally from the current PC. Decode them and register the control fields at the FETCH->EXEC edge:
  - legal instruction -> EXEC
  - opcode 6'h3F -> HALT
  - anything else -> ERR
- Decode table (alu_funct, rd_mux_s, op2_mux_s, wr):
  - opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or or 0x2A slt -> (funct, 1, 0, 1)
  - opcode 0x00 with any other funct -> illegal
  - 0x08 addi -> (0x20, 0, 1, 1)
  - 0x0C andi -> (0x24, 0, 1, 1)
  - 0x0D ori -> (0x25, 0, 1, 1)
  - 0x04 beq -> (0x22, 0, 0, 0); is_beq=1
- EXEC: mux selects and alu_funct are driven from the decode registers; load=0, write=0. Allows the ALU result to settle. Next state is COMMIT.
- COMMIT (exactly one cycle):
  - selects are held; load=1; write=wr.
  - branch_mux_s = is_beq & zero, evaluated combinationally in this cycle.
  - instr_count increments, saturating at all-ones.
  - Next state is FETCH if run==1, else IDLE.
- Per-instruction latency is 3 cycles, with PC and register file updating on the COMMIT edge. Outside COMMIT: load=write=branch_mux_s=0.
- busy=1 in FETCH/EXEC/COMMIT; busy=0 in IDLE/HALT/ERR.
- run deasserted in FETCH or EXEC: the current instruction still completes through COMMIT, then the FSM goes to IDLE.
- HALT: halted=1; PC is not loaded, so PC stays at the HALT instruction; HALT counts as retired (instr_count +1 on entry). Only reset exits HALT; run is ignored.
- ERR: illegal=1; no load/write is issued for the faulting instruction; it is not counted. Only reset exits ERR.
- In IDLE/HALT/ERR, alu_funct, rd_mux_s and op2_mux_s are 0.

Test Plan:
- Reset with run=1 → all outputs 0 and state IDLE. Release reset → busy=1 one cycle later. load pulses once every 3 cycles.
- addi (op 0x08) then add (op 0x00, funct 0x20) with run=1 → first COMMIT shows write=1, rd_mux_s=0, op2_mux_s=1, alu_funct=0x20. Second COMMIT shows rd_mux_s=1, op2_mux_s=0. instr_count=2 after 6 cycles.
- beq (op 0x04), zero=1 in COMMIT → branch_mux_s=1, load=1, write=0. Repeat with zero=0 → branch_mux_s=0. zero toggling during EXEC has no effect on outputs.
- Opcode 0x3F after 3 instructions → halted=1, busy=0, instr_count=4, load stays 0 for 20 cycles with run=1. Apply reset → halted=0.
- Opcode 0x00 with funct 0x03, and separately opcode 0x23 → illegal=1, no write/load pulse, instr_count unchanged.
- run dropped in EXEC → COMMIT still occurs, then IDLE with busy=0. run raised again → FETCH next cycle. Reset asserted in EXEC → no COMMIT pulse, state IDLE.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm
//   Multi-cycle controller for the op_aut datapath. Every instruction runs
//   FETCH -> EXEC -> COMMIT.
//   - FETCH decodes opcode/funct and latches the control fields.
//   - EXEC drives the ALU and mux selects so the result can settle.
//   - COMMIT pulses the PC load and the register write for one cycle.
//   The controller also provides run/halt control, an illegal-instruction
//   trap and a saturating retired-instruction counter.
//
// Ports
//   clock        : system clock, all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   run          : 1 = execute, 0 = stop at the next instruction boundary
//   opcode       : instruction[31:26] from the datapath
//   funct        : instruction[5:0] from the datapath
//   zero         : ALU zero flag from the datapath
//   load         : PC load enable (COMMIT only)
//   write        : register-file write enable (COMMIT only)
//   rd_mux_s     : 0 = write rt, 1 = write rd
//   op2_mux_s    : 0 = rdata2, 1 = sign-extended immediate
//   branch_mux_s : 0 = PC+4, 1 = PC+4+imm
//   alu_funct    : ALU operation (MIPS funct encoding)
//   busy         : 1 in FETCH/EXEC/COMMIT
//   halted       : sticky, a HALT instruction retired
//   illegal      : sticky, an unsupported instruction was decoded
//   instr_count  : retired instructions, saturating
module control_fsm #(
  parameter int CountWidth = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  output logic                  load,
  output logic                  write,
  output logic                  rd_mux_s,
  output logic                  op2_mux_s,
  output logic                  branch_mux_s,
  output logic [5:0]            alu_funct,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [CountWidth-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Combinational decode of the instruction presented during FETCH.
  logic [5:0] fetch_funct;
  logic       fetch_rd, fetch_op2, fetch_wr, fetch_beq, fetch_legal, fetch_halt;

  // Decode registers, latched on the FETCH->EXEC edge.
  logic [5:0] dec_funct;
  logic       dec_rd, dec_op2, dec_wr, dec_beq;

  always_comb begin
    fetch_funct = 6'h00;
    fetch_rd    = 1'b0;
    fetch_op2   = 1'b0;
    fetch_wr    = 1'b0;
    fetch_beq   = 1'b0;
    fetch_legal = 1'b1;
    fetch_halt  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
            fetch_funct = funct;
            fetch_rd    = 1'b1;
            fetch_wr    = 1'b1;
          end
          default: fetch_legal = 1'b0;
        endcase
      end
      6'h08: begin fetch_funct = 6'h20; fetch_op2 = 1'b1; fetch_wr = 1'b1; end
      6'h0C: begin fetch_funct = 6'h24; fetch_op2 = 1'b1; fetch_wr = 1'b1; end
      6'h0D: begin fetch_funct = 6'h25; fetch_op2 = 1'b1; fetch_wr = 1'b1; end
      6'h04: begin fetch_funct = 6'h22; fetch_beq = 1'b1; end
      6'h3F: begin fetch_legal = 1'b0; fetch_halt = 1'b1; end
      default: fetch_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FETCH -> EXEC boundary: capture the decoded control fields
  always_ff @(posedge clock) begin
    if (!reset) begin
      dec_funct <= 6'h00;
      dec_rd    <= 1'b0;
      dec_op2   <= 1'b0;
      dec_wr    <= 1'b0;
      dec_beq   <= 1'b0;
    end else if (state == FETCH && fetch_legal) begin
      dec_funct <= fetch_funct;
      dec_rd    <= fetch_rd;
      dec_op2   <= fetch_op2;
      dec_wr    <= fetch_wr;
      dec_beq   <= fetch_beq;
    end
  end

  // A HALT retires on its way into HALT, every other instruction in COMMIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_count <= '0;
    end else if ((state == COMMIT) || (state == FETCH && fetch_halt)) begin
      if (~&instr_count)
        instr_count <= instr_count + {{(CountWidth-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    write        = 1'b0;
    rd_mux_s     = 1'b0;
    op2_mux_s    = 1'b0;
    branch_mux_s = 1'b0;
    alu_funct    = 6'h00;
    busy         = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (fetch_legal)     state_nxt = EXEC;
        else if (fetch_halt) state_nxt = HALT;
        else                 state_nxt = ERR;
      end
      EXEC: begin
        busy      = 1'b1;
        rd_mux_s  = dec_rd;
        op2_mux_s = dec_op2;
        alu_funct = dec_funct;
        state_nxt = COMMIT;
      end
      COMMIT: begin
        busy         = 1'b1;
        rd_mux_s     = dec_rd;
        op2_mux_s    = dec_op2;
        alu_funct    = dec_funct;
        // Gated by reset so an aborted instruction never updates PC/regfile.
        load         = reset;
        write        = dec_wr & reset;
        branch_mux_s = dec_beq & zero & reset;
        state_nxt    = run ? FETCH : IDLE;
      end
      HALT:    halted  = 1'b1;
      ERR:     illegal = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
